jtag_tap_multi: RTL

Parametrised JTAG test access port, the next generation of the team's fixed 6-bit-IR JTAG stub. Compared with that stub it adds:
- configurable IR width;
- N scratch data registers of configurable width, each with a parallel output and an update strobe;
- a read-only status register sampled from fabric;
- a `tdo_en` output;
- full IEEE 1149.1 capture/update semantics, with unknown opcodes treated as BYPASS.

It sits between the chip-level JTAG pins and on-chip debug/config logic.

---
 rtl/jtag_pkg.sv | 62 ++++++
 rtl/jtag_tap_fsm.sv | 63 ++++++
 rtl/jtag_tap_multi.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared TAP state encodings, opcode constants and the
//               IEEE 1149.1 next-state function for jtag_tap_multi.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  // TAP states in standard order
  typedef enum logic [3:0] {
    TAP_RESET    = 4'h0,
    TAP_IDLE     = 4'h1,
    TAP_SEL_DR   = 4'h2,
    TAP_CAP_DR   = 4'h3,
    TAP_SHIFT_DR = 4'h4,
    TAP_EX1_DR   = 4'h5,
    TAP_PAUSE_DR = 4'h6,
    TAP_EX2_DR   = 4'h7,
    TAP_UPD_DR   = 4'h8,
    TAP_SEL_IR   = 4'h9,
    TAP_CAP_IR   = 4'hA,
    TAP_SHIFT_IR = 4'hB,
    TAP_EX1_IR   = 4'hC,
    TAP_PAUSE_IR = 4'hD,
    TAP_EX2_IR   = 4'hE,
    TAP_UPD_IR   = 4'hF
  } tap_state_t;

  // Opcodes; BYPASS is all-ones at whatever IR width is in use
  localparam int OPC_BYPASS       = -1;
  localparam int OPC_IDCODE       = 1;
  localparam int OPC_STATUS       = 2;
  localparam int OPC_SCRATCH_BASE = 4;

  // Standard 16-state TAP transition graph
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TAP_RESET:    n = tms ? TAP_RESET    : TAP_IDLE;
      TAP_IDLE:     n = tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_EX1_DR:   n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_IR:   n = tms ? TAP_RESET    : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_EX1_IR:   n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_IDLE;
      default:      n = TAP_RESET;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : IEEE 1149.1 TAP controller with registered state and
//               registered per-state capture/shift/update decode flags.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] o_state,
  output logic       o_tlr,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir
);

  tap_state_t r_state;
  tap_state_t w_next;
  logic       r_tlr, r_cap_dr, r_sh_dr, r_upd_dr, r_cap_ir, r_sh_ir, r_upd_ir;

  assign w_next = tap_next(r_state, tms);

  // Advance the TAP and decode the flags from the next state so they align with r_state
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_state  <= TAP_RESET;
      r_tlr    <= 1'b1;
      r_cap_dr <= 1'b0;
      r_sh_dr  <= 1'b0;
      r_upd_dr <= 1'b0;
      r_cap_ir <= 1'b0;
      r_sh_ir  <= 1'b0;
      r_upd_ir <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_tlr    <= (w_next == TAP_RESET);
      r_cap_dr <= (w_next == TAP_CAP_DR);
      r_sh_dr  <= (w_next == TAP_SHIFT_DR);
      r_upd_dr <= (w_next == TAP_UPD_DR);
      r_cap_ir <= (w_next == TAP_CAP_IR);
      r_sh_ir  <= (w_next == TAP_SHIFT_IR);
      r_upd_ir <= (w_next == TAP_UPD_IR);
    end
  end

  assign o_state      = r_state;
  assign o_tlr        = r_tlr;
  assign o_capture_dr = r_cap_dr;
  assign o_shift_dr   = r_sh_dr;
  assign o_update_dr  = r_upd_dr;
  assign o_capture_ir = r_cap_ir;
  assign o_shift_ir   = r_sh_ir;
  assign o_update_ir  = r_upd_ir;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_multi
// Description : Parametrised JTAG TAP with IDCODE, fabric STATUS capture,
//               N scratch data registers with update strobes, and BYPASS
//               for every unassigned opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_multi
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = 4,
  parameter int          NUM_SCRATCH   = 2,
  parameter int          SCRATCH_WIDTH = 16,
  parameter logic [31:0] IDCODE_VAL    = 32'hbeefcafe
) (
  input  logic                                 tck,
  input  logic                                 trst,
  input  logic                                 tms,
  input  logic                                 tdi,
  output logic                                 tdo,
  output logic                                 tdo_en,
  input  logic [SCRATCH_WIDTH-1:0]             status_in,
  output logic [NUM_SCRATCH*SCRATCH_WIDTH-1:0] scratch_out,
  output logic [NUM_SCRATCH-1:0]               update_strb,
  output logic [3:0]                           tap_state
);

  localparam int DRW = (SCRATCH_WIDTH > 32) ? SCRATCH_WIDTH : 32;
  localparam int LW  = $clog2(DRW + 1);

  logic w_tlr, w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir;

  logic [IR_WIDTH-1:0]                  r_ir;
  logic [IR_WIDTH-1:0]                  r_irsh;
  logic [DRW-1:0]                       r_dr;
  logic [NUM_SCRATCH*SCRATCH_WIDTH-1:0] r_scratch;
  logic [NUM_SCRATCH-1:0]               r_strb;
  logic                                 r_tdo;
  logic                                 r_tdo_en;

  logic [NUM_SCRATCH-1:0] w_hit;
  logic                   w_sel_id;
  logic                   w_sel_st;
  logic [LW-1:0]          w_len;
  logic [DRW-1:0]         w_cap;
  logic [DRW-1:0]         w_dr_shift;

  jtag_tap_fsm u_fsm (
    .tck          (tck),
    .trst         (trst),
    .tms          (tms),
    .o_state      (tap_state),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_cap_dr),
    .o_shift_dr   (w_sh_dr),
    .o_update_dr  (w_upd_dr),
    .o_capture_ir (w_cap_ir),
    .o_shift_ir   (w_sh_ir),
    .o_update_ir  (w_upd_ir)
  );

  // Opcode decode: anything not matched here falls through to a 1-bit bypass
  for (genvar k = 0; k < NUM_SCRATCH; k++) begin : g_dec
    assign w_hit[k] = (r_ir == IR_WIDTH'(OPC_SCRATCH_BASE + k));
  end

  assign w_sel_id = (r_ir == IR_WIDTH'(OPC_IDCODE));
  assign w_sel_st = (r_ir == IR_WIDTH'(OPC_STATUS));
  assign w_len    = w_sel_id ? LW'(32) :
                    (w_sel_st || (|w_hit)) ? LW'(SCRATCH_WIDTH) : LW'(1);

  // Capture source for the selected data register
  always_comb begin
    w_cap = '0;
    if (w_sel_id) begin
      w_cap[31:0] = IDCODE_VAL;
    end else if (w_sel_st) begin
      w_cap[SCRATCH_WIDTH-1:0] = status_in;
    end else begin
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (w_hit[k]) w_cap[SCRATCH_WIDTH-1:0] = r_scratch[k*SCRATCH_WIDTH +: SCRATCH_WIDTH];
      end
    end
  end

  // One shift step: tdi lands at bit len-1, lower bits move right, upper bits hold
  always_comb begin
    w_dr_shift = r_dr;
    for (int i = 0; i < DRW - 1; i++) begin
      if (i < int'(w_len) - 1) w_dr_shift[i] = r_dr[i+1];
    end
    for (int i = 0; i < DRW; i++) begin
      if (i == int'(w_len) - 1) w_dr_shift[i] = tdi;
    end
  end

  // Posedge capture/shift of the IR and DR shift registers
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_dr   <= '0;
      r_irsh <= '0;
    end else begin
      if (w_cap_dr)     r_dr <= w_cap;
      else if (w_sh_dr) r_dr <= w_dr_shift;
      if (w_cap_ir)     r_irsh <= IR_WIDTH'(1);
      else if (w_sh_ir) r_irsh <= {tdi, r_irsh[IR_WIDTH-1:1]};
    end
  end

  // Negedge updates, strobes and serial output; TLR restores IDCODE but keeps scratch
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      r_ir      <= IR_WIDTH'(OPC_IDCODE);
      r_scratch <= '0;
      r_strb    <= '0;
      r_tdo     <= 1'b0;
      r_tdo_en  <= 1'b0;
    end else begin
      r_tdo_en <= w_sh_dr | w_sh_ir;
      if (w_sh_dr)      r_tdo <= r_dr[0];
      else if (w_sh_ir) r_tdo <= r_irsh[0];
      if (w_tlr)          r_ir <= IR_WIDTH'(OPC_IDCODE);
      else if (w_upd_ir)  r_ir <= r_irsh;
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        r_strb[k] <= w_upd_dr & w_hit[k];
        if (w_upd_dr && w_hit[k])
          r_scratch[k*SCRATCH_WIDTH +: SCRATCH_WIDTH] <= r_dr[SCRATCH_WIDTH-1:0];
      end
    end
  end

  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;
  assign scratch_out = r_scratch;
  assign update_strb = r_strb;

endmodule
`default_nettype wire
